// File: rtl/loader_pkg.sv
// Shared types and helpers for the UART program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    LD_WAIT_SYNC,
    LD_GET_LEN,
    LD_DATA,
    LD_CHECK,
    LD_DONE,
    LD_ERR
  } ld_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;

  // Clock cycles per UART bit; callers must keep the result >= 8.
  function automatic int unsigned calc_bit_cyc(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_prog_loader_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, glitch-rejecting start detect,
// one-cycle rx_valid / rx_ferr strobes.
module uart_rx_core
  import loader_pkg::*;
#(
  parameter int unsigned BIT_CYC = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_ferr
);

  localparam int unsigned HALF_CYC = BIT_CYC / 2;

  rx_state_t   state, state_nxt;
  logic        rx_m, rx_s, rx_q;
  logic [31:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        bit_tick, half_tick, fall;

  assign bit_tick  = (cnt == BIT_CYC - 1);
  assign half_tick = (cnt == HALF_CYC - 1);
  assign fall      = rx_q & ~rx_s;

  // Input synchronizer plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
    end else begin
      rx_m <= uart_rx;
      rx_s <= rx_m;
      rx_q <= rx_s;
    end
  end

  // RX state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_nxt;
  end

  // RX next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      RX_IDLE:  if (fall) state_nxt = RX_START;
      RX_START: if (half_tick) state_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && bit_idx == 3'd7) state_nxt = RX_STOP;
      RX_STOP:  if (bit_tick) state_nxt = RX_IDLE;
      default:  state_nxt = RX_IDLE;
    endcase
  end

  // Bit timer and LSB-first shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == RX_IDLE || state_nxt != state || bit_tick) cnt <= '0;
      else                                                    cnt <= cnt + 32'd1;
      if (state == RX_START) bit_idx <= '0;
      if (state == RX_DATA && bit_tick) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  // Stop-bit strobes.
  always_comb begin
    rx_valid = (state == RX_STOP) && bit_tick && rx_s;
    rx_ferr  = (state == RX_STOP) && bit_tick && !rx_s;
    rx_byte  = shreg;
  end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: SYNC, length N, 4N little-endian data bytes, then
// (with LOADER_CHECKSUM_EN defined) one checksum byte. Writes each word to
// instruction memory and holds the core in reset until the image is complete.
module uart_prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLK_FREQ    = 100_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned BIT_CYC = calc_bit_cyc(CLK_FREQ, BAUD);

  logic        rx_valid, rx_ferr;
  logic [7:0]  rx_byte;
  ld_state_t   state, state_nxt;
  logic [7:0]  len_m1, word_idx;
  logic [1:0]  byte_idx;
  logic [23:0] asm_q;
  logic [31:0] tcnt;
  logic        in_sess, timeout, sync_hit, last_wr, fail_ev;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  uart_rx_core #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .rx_ferr  (rx_ferr)
  );

  assign in_sess  = (state == LD_GET_LEN) || (state == LD_DATA) || (state == LD_CHECK);
  assign timeout  = in_sess && (tcnt == TIMEOUT_CYC);
  assign sync_hit = rx_valid && (rx_byte == SYNC_BYTE);
  assign last_wr  = wr_en && (word_idx == len_m1);
  // A received byte outranks a coincident timeout.
  assign fail_ev  = !rx_valid && (rx_ferr || timeout);

  // Loader state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LD_WAIT_SYNC;
    else        state <= state_nxt;
  end

  // Loader next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      LD_WAIT_SYNC, LD_DONE, LD_ERR: if (sync_hit) state_nxt = LD_GET_LEN;
      LD_GET_LEN: begin
        if (rx_valid)     state_nxt = LD_DATA;
        else if (fail_ev) state_nxt = LD_ERR;
      end
      LD_DATA: begin
`ifdef LOADER_CHECKSUM_EN
        if (last_wr)      state_nxt = LD_CHECK;
`else
        if (last_wr)      state_nxt = LD_DONE;
`endif
        else if (fail_ev) state_nxt = LD_ERR;
      end
`ifdef LOADER_CHECKSUM_EN
      LD_CHECK: begin
        if (rx_valid)     state_nxt = (rx_byte == csum) ? LD_DONE : LD_ERR;
        else if (fail_ev) state_nxt = LD_ERR;
      end
`endif
      default: state_nxt = LD_WAIT_SYNC;
    endcase
  end

  // Inter-byte idle counter, saturating at the timeout value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    tcnt <= '0;
    else if (!in_sess || rx_valid) tcnt <= '0;
    else if (tcnt != TIMEOUT_CYC)  tcnt <= tcnt + 32'd1;
  end

  // Length capture, word assembly, write strobe and checksum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      len_m1   <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      asm_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (state == LD_GET_LEN && rx_valid) begin
        len_m1   <= rx_byte - 8'd1;
        word_idx <= '0;
        byte_idx <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum     <= '0;
`endif
      end
      if (state == LD_DATA) begin
        if (rx_valid) begin
          byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
          csum     <= csum + rx_byte;
`endif
          case (byte_idx)
            2'd0:    asm_q[7:0]   <= rx_byte;
            2'd1:    asm_q[15:8]  <= rx_byte;
            2'd2:    asm_q[23:16] <= rx_byte;
            default: begin
              wr_en   <= 1'b1;
              wr_addr <= word_idx;
              wr_data <= {rx_byte, asm_q};
            end
          endcase
        end
        if (wr_en) word_idx <= word_idx + 8'd1;
      end
    end
  end

  // Status outputs decoded from the loader state.
  always_comb begin
    busy      = in_sess;
    done      = (state == LD_DONE);
    err       = (state == LD_ERR);
    cpu_rst_n = !(in_sess || (state == LD_ERR));
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader at 10 clock cycles per UART bit.
// Build with +define+LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_uart_prog_loader;

  localparam int BITC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst_n, busy, done, err;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wa_q[$];
  logic [31:0] wd_q[$];

  uart_prog_loader #(
    .CLK_FREQ    (1_000_000),
    .BAUD        (100_000),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CYC (500)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .cpu_rst_n (cpu_rst_n),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Record every cycle in which the write strobe is high.
  always @(negedge clk) begin
    if (wr_en) begin
      wa_q.push_back(wr_addr);
      wd_q.push_back(wr_data);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    repeat (BITC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BITC) @(negedge clk);
    end
    uart_rx = stop;
    repeat (BITC) @(negedge clk);
    uart_rx = 1'b1;
  endtask

  task automatic wait_settle();
    for (int i = 0; i < 60; i++) begin
      if (done || err) break;
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err} !== {1'b0, 8'h00, 32'h0, 4'b1000}) begin
      errors++;
      $display("FAIL reset_vals got %h required %h", {wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err},
               {1'b0, 8'h00, 32'h0, 4'b1000});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_noise();
    clear_log();
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (20) @(negedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (wa_q.size() !== 0) begin
      errors++; $display("FAIL noise_writes got %0d required 0", wa_q.size());
    end
    checks++;
    if ({cpu_rst_n, busy, done, err} !== 4'b1000) begin
      errors++; $display("FAIL noise_status got %b required 1000", {cpu_rst_n, busy, done, err});
    end
  endtask

  task automatic test_basic_load();
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h02, 1'b1);
    checks++;
    if ({cpu_rst_n, busy, done, err} !== 4'b0100) begin
      errors++; $display("FAIL basic_in_session got %b required 0100", {cpu_rst_n, busy, done, err});
    end
    send_byte(8'h13, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h00, 1'b1);
    send_byte(8'h93, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h10, 1'b1); send_byte(8'h00, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hB6, 1'b1);
`endif
    wait_settle();
    checks++;
    if (wa_q.size() !== 2) begin
      errors++; $display("FAIL basic_writes got %0d required 2", wa_q.size());
    end
    if (wa_q.size() == 2) begin
      checks++;
      if ({wa_q[0], wd_q[0]} !== {8'h00, 32'h00000013}) begin
        errors++; $display("FAIL basic_word0 got %h/%h required 00/00000013", wa_q[0], wd_q[0]);
      end
      checks++;
      if ({wa_q[1], wd_q[1]} !== {8'h01, 32'h00100093}) begin
        errors++; $display("FAIL basic_word1 got %h/%h required 01/00100093", wa_q[1], wd_q[1]);
      end
    end
    checks++;
    if ({cpu_rst_n, busy, done, err} !== 4'b1010) begin
      errors++; $display("FAIL basic_status got %b required 1010", {cpu_rst_n, busy, done, err});
    end
  endtask

  task automatic test_timeout();
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    repeat (300) @(negedge clk);
    checks++;
    if ({cpu_rst_n, busy, done, err} !== 4'b0100) begin
      errors++; $display("FAIL timeout_early got %b required 0100", {cpu_rst_n, busy, done, err});
    end
    repeat (300) @(negedge clk);
    checks++;
    if ({cpu_rst_n, busy, done, err} !== 4'b0001) begin
      errors++; $display("FAIL timeout_status got %b required 0001", {cpu_rst_n, busy, done, err});
    end
    checks++;
    if (wa_q.size() !== 0) begin
      errors++; $display("FAIL timeout_writes got %0d required 0", wa_q.size());
    end
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum();
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b1);
    wait_settle();
    checks++;
    if (wa_q.size() !== 1) begin
      errors++; $display("FAIL csum_bad_writes got %0d required 1", wa_q.size());
    end
    if (wa_q.size() == 1) begin
      checks++;
      if ({wa_q[0], wd_q[0]} !== {8'h00, 32'h04030201}) begin
        errors++; $display("FAIL csum_bad_word got %h/%h required 00/04030201", wa_q[0], wd_q[0]);
      end
    end
    checks++;
    if ({cpu_rst_n, busy, done, err} !== 4'b0001) begin
      errors++; $display("FAIL csum_bad_status got %b required 0001", {cpu_rst_n, busy, done, err});
    end
    clear_log();
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'h01, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h04, 1'b1);
    send_byte(8'h0A, 1'b1);
    wait_settle();
    checks++;
    if ({cpu_rst_n, busy, done, err} !== 4'b1010) begin
      errors++; $display("FAIL csum_good_status got %b required 1010", {cpu_rst_n, busy, done, err});
    end
  endtask
`endif

  task automatic test_framing();
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h55, 1'b0);
    repeat (5) @(negedge clk);
    checks++;
    if ({cpu_rst_n, busy, done, err} !== 4'b0001) begin
      errors++; $display("FAIL ferr_status got %b required 0001", {cpu_rst_n, busy, done, err});
    end
    checks++;
    if (wa_q.size() !== 0) begin
      errors++; $display("FAIL ferr_writes got %0d required 0", wa_q.size());
    end
  endtask

  task automatic test_full_256();
    logic [7:0]  b0, b1, b2, b3, sum;
    logic [31:0] exp_w [256];
    clear_log();
    sum = 8'h00;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 256; i++) begin
      b0 = 8'(i);
      b1 = ~b0;
      b2 = 8'h5A;
      b3 = b0 + 8'h11;
      exp_w[i] = {b3, b2, b1, b0};
      sum = sum + b0 + b1 + b2 + b3;
      send_byte(b0, 1'b1); send_byte(b1, 1'b1); send_byte(b2, 1'b1); send_byte(b3, 1'b1);
    end
`ifdef LOADER_CHECKSUM_EN
    send_byte(sum, 1'b1);
`endif
    wait_settle();
    checks++;
    if (wa_q.size() !== 256) begin
      errors++; $display("FAIL n0_writes got %0d required 256", wa_q.size());
    end
    if (wa_q.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        checks++;
        if ({wa_q[i], wd_q[i]} !== {8'(i), exp_w[i]}) begin
          errors++; $display("FAIL n0_word%0d got %h/%h required %h/%h", i, wa_q[i], wd_q[i], 8'(i), exp_w[i]);
        end
      end
    end
    checks++;
    if ({cpu_rst_n, busy, done, err} !== 4'b1010) begin
      errors++; $display("FAIL n0_status got %b required 1010", {cpu_rst_n, busy, done, err});
    end
  endtask

  task automatic test_reset_mid();
    clear_log();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h11, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err} !== {1'b0, 8'h00, 32'h0, 4'b1000}) begin
      errors++;
      $display("FAIL midrst_vals got %h required %h", {wr_en, wr_addr, wr_data, cpu_rst_n, busy, done, err},
               {1'b0, 8'h00, 32'h0, 4'b1000});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h22, 1'b1); send_byte(8'h33, 1'b1); send_byte(8'h44, 1'b1);
    repeat (5) @(negedge clk);
    checks++;
    if (wa_q.size() !== 0 || {cpu_rst_n, busy, done, err} !== 4'b1000) begin
      errors++;
      $display("FAIL midrst_abort got writes=%0d status=%b required 0/1000", wa_q.size(), {cpu_rst_n, busy, done, err});
    end
    send_byte(8'hA5, 1'b1); send_byte(8'h01, 1'b1);
    send_byte(8'hDE, 1'b1); send_byte(8'hAD, 1'b1); send_byte(8'hBE, 1'b1); send_byte(8'hEF, 1'b1);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'h38, 1'b1);
`endif
    wait_settle();
    checks++;
    if (wa_q.size() !== 1) begin
      errors++; $display("FAIL midrst_writes got %0d required 1", wa_q.size());
    end
    if (wa_q.size() == 1) begin
      checks++;
      if ({wa_q[0], wd_q[0]} !== {8'h00, 32'hEFBEADDE}) begin
        errors++; $display("FAIL midrst_word got %h/%h required 00/efbeadde", wa_q[0], wd_q[0]);
      end
    end
    checks++;
    if ({cpu_rst_n, busy, done, err} !== 4'b1010) begin
      errors++; $display("FAIL midrst_status got %b required 1010", {cpu_rst_n, busy, done, err});
    end
  endtask

  initial begin
    test_reset();
    test_noise();
    test_basic_load();
    test_timeout();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_framing();
    test_full_256();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
